// File: rtl/px_adc_capture.sv
// -----------------------------------------------------------------------------
// px_adc_capture
//   Serial front end for the four pixel ADCs. One start request runs one
//   conversion frame on the shared chip-select / serial-clock bus and
//   deserialises the four ADC data lines in parallel. The frame is
//   LEAD_ZEROS leading bits followed by ADC_BITS data bits, MSB first.
//   The four samples are presented together with a one-cycle valid strobe.
//   A leading bit read back as 1 is reported per channel in frame_err.
//
//   Frame sequence: IDLE -> SETUP (cs low, sclk high) -> SHIFT (FRAME_BITS
//   sclk periods) -> QUIET (cs high) -> IDLE. Starts that arrive while the
//   block is busy are dropped.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous reset, active-high
//   start          in   one-cycle request to begin a frame (ignored when busy)
//   px0..3_adc_din in   serial data from pixel ADC 0..3, synchronous to clk
//   px_adc_cs      out  chip select, active-low, shared by all four ADCs
//   px_adc_sclk    out  serial clock, idles high
//   busy           out  high from the cycle after an accepted start until
//                       the quiet period ends
//   sample_valid   out  one-cycle strobe; sample_data/frame_err update here
//   sample_data    out  {px3, px2, px1, px0}, ADC_BITS per field
//   frame_err      out  per-channel flag: a leading bit was read back as 1
// -----------------------------------------------------------------------------
module px_adc_capture #(
  parameter int ADC_BITS     = 12,
  parameter int LEAD_ZEROS   = 4,
  parameter int SCLK_DIV     = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    px0_adc_din,
  input  logic                    px1_adc_din,
  input  logic                    px2_adc_din,
  input  logic                    px3_adc_din,
  output logic                    px_adc_cs,
  output logic                    px_adc_sclk,
  output logic                    busy,
  output logic                    sample_valid,
  output logic [4*ADC_BITS-1:0]   sample_data,
  output logic [3:0]              frame_err
);

  localparam int FRAME_BITS = LEAD_ZEROS + ADC_BITS;
  localparam int NUM_CH     = 4;

  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_BITS);
  localparam int QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  // Data field of a received frame: the low ADC_BITS bits.
  function automatic logic [ADC_BITS-1:0] payload_of(input logic [FRAME_BITS-1:0] frame);
    return frame[ADC_BITS-1:0];
  endfunction

  // Any leading bit that came back as 1 marks the frame as suspect.
  function automatic logic lead_err_of(input logic [FRAME_BITS-1:0] frame);
    return |frame[FRAME_BITS-1:ADC_BITS];
  endfunction

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [QUIET_W-1:0]      quiet_q, quiet_d;
  logic                    cs_q, cs_d;
  logic                    sclk_q, sclk_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [4*ADC_BITS-1:0]   sample_data_q, sample_data_d;
  logic [NUM_CH-1:0]       frame_err_q, frame_err_d;

  logic [NUM_CH-1:0]       din;
  logic                    shift_en;
  logic [FRAME_BITS-1:0]   shreg_q [NUM_CH];

  assign din = {px3_adc_din, px2_adc_din, px1_adc_din, px0_adc_din};

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_d         = bit_q;
    quiet_d       = quiet_q;
    cs_d          = cs_q;
    sclk_d        = sclk_q;
    busy_d        = busy_q;
    valid_d       = 1'b0;
    sample_data_d = sample_data_q;
    frame_err_d   = frame_err_q;
    shift_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          busy_d  = 1'b1;
          div_d   = '0;
        end
      end

      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            // End of the low phase: this edge raises sclk and captures din.
            sclk_d   = 1'b1;
            shift_en = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            // End of the last high phase: close the frame and publish it.
            // The last bit was captured at the preceding rising sclk edge,
            // so the shift registers already hold the complete frame.
            state_d = QUIET;
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
            valid_d = 1'b1;
            quiet_d = '0;
            bit_d   = '0;
            for (int k = 0; k < NUM_CH; k++) begin
              sample_data_d[k*ADC_BITS +: ADC_BITS] = payload_of(shreg_q[k]);
              frame_err_d[k]                        = lead_err_of(shreg_q[k]);
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b0;
          end
        end
      end

      QUIET: begin
        if (quiet_q == QUIET_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      quiet_q       <= '0;
      cs_q          <= 1'b1;
      sclk_q        <= 1'b1;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      sample_data_q <= '0;
      frame_err_q   <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      quiet_q       <= quiet_d;
      cs_q          <= cs_d;
      sclk_q        <= sclk_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      sample_data_q <= sample_data_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Deserialisers: every bit is overwritten during a frame, so no reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shreg_q[k] <= {shreg_q[k][FRAME_BITS-2:0], din[k]};
      end
    end
  end

  assign px_adc_cs    = cs_q;
  assign px_adc_sclk  = sclk_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample_data  = sample_data_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_px_adc_capture.sv
// Directed bench for px_adc_capture. Instance A uses the default parameters;
// instance B runs with SCLK_DIV=1, QUIET_CYCLES=1 for back-to-back frames.
// A behavioural ADC per instance launches one frame bit on each falling sclk
// edge while cs is low, MSB first.
module tb_px_adc_capture;

  localparam int FB       = 16;
  localparam int DIV_A    = 2;
  localparam int QUIET_A  = 4;
  localparam int LAT_A    = 1 + DIV_A * (1 + 2 * FB);   // start cycle -> valid cycle
  localparam int BUSY_A   = DIV_A * (1 + 2 * FB) + QUIET_A;
  localparam int LAT_B    = 1 + 1 * (1 + 2 * FB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic [3:0]  din_a, din_b;
  logic        cs_a, sclk_a, busy_a, valid_a;
  logic        cs_b, sclk_b, busy_b, valid_b;
  logic [47:0] data_a, data_b;
  logic [3:0]  err_a, err_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] word_a [4];
  logic [15:0] word_b [4];
  int          idx_a = 0;
  int          idx_b = 0;

  px_adc_capture dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .px0_adc_din(din_a[0]), .px1_adc_din(din_a[1]),
    .px2_adc_din(din_a[2]), .px3_adc_din(din_a[3]),
    .px_adc_cs(cs_a), .px_adc_sclk(sclk_a), .busy(busy_a),
    .sample_valid(valid_a), .sample_data(data_a), .frame_err(err_a)
  );

  px_adc_capture #(.SCLK_DIV(1), .QUIET_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .px0_adc_din(din_b[0]), .px1_adc_din(din_b[1]),
    .px2_adc_din(din_b[2]), .px3_adc_din(din_b[3]),
    .px_adc_cs(cs_b), .px_adc_sclk(sclk_b), .busy(busy_b),
    .sample_valid(valid_b), .sample_data(data_b), .frame_err(err_b)
  );

  // ADC models: cs falling (sclk high) rewinds the bit index; each sclk fall
  // with cs low launches the next bit.
  always @(negedge sclk_a or negedge cs_a) begin
    if (!cs_a && sclk_a) begin
      idx_a = 0;
    end else if (!cs_a && !sclk_a && idx_a < FB) begin
      for (int k = 0; k < 4; k++) din_a[k] = word_a[k][FB-1-idx_a];
      idx_a = idx_a + 1;
    end
  end

  always @(negedge sclk_b or negedge cs_b) begin
    if (!cs_b && sclk_b) begin
      idx_b = 0;
    end else if (!cs_b && !sclk_b && idx_b < FB) begin
      for (int k = 0; k < 4; k++) din_b[k] = word_b[k][FB-1-idx_b];
      idx_b = idx_b + 1;
    end
  end

  // One frame on instance A: start in cycle 0, then observe 120 cycles at
  // the falling clk edge. Cycle c is the c-th cycle after the start cycle.
  task automatic run_frame_a(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3,
                             output int lat, output int falls, output int busy_cyc,
                             output int nvalid, output logic sclk_at_fall,
                             output logic sclk_at_rise);
    logic pcs, psclk;
    word_a[0] = w0; word_a[1] = w1; word_a[2] = w2; word_a[3] = w3;
    lat = -1; falls = 0; busy_cyc = 0; nvalid = 0;
    sclk_at_fall = 1'bx; sclk_at_rise = 1'bx;
    @(negedge clk);
    start_a = 1'b1;
    pcs = cs_a; psclk = sclk_a;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (busy_a) busy_cyc++;
      if (pcs && !cs_a) sclk_at_fall = sclk_a;
      if (!pcs && cs_a) sclk_at_rise = sclk_a;
      if (!cs_a && psclk && !sclk_a) falls++;
      if (valid_a) begin
        nvalid++;
        if (lat < 0) lat = c;
      end
      pcs = cs_a; psclk = sclk_a;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; din_a = '0; din_b = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (cs_a !== 1'b1) $display("FAIL reset_cs: got %b want 1", cs_a); else n_pass++;
    n_checks++; if (sclk_a !== 1'b1) $display("FAIL reset_sclk: got %b want 1", sclk_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_a); else n_pass++;
    n_checks++; if (data_a !== 48'h0) $display("FAIL reset_data: got %h want 0", data_a); else n_pass++;
    n_checks++; if (err_a !== 4'h0) $display("FAIL reset_err: got %b want 0000", err_a); else n_pass++;
    n_checks++; if ({cs_b, sclk_b, busy_b} !== 3'b110) $display("FAIL reset_b: got %b want 110", {cs_b, sclk_b, busy_b}); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, falls, bc, nv; logic sf, sr;
    run_frame_a(16'h0ABC, 16'h0123, 16'h0FFF, 16'h0000, lat, falls, bc, nv, sf, sr);
    n_checks++; if (lat !== LAT_A) $display("FAIL t1_latency: got %0d want %0d", lat, LAT_A); else n_pass++;
    n_checks++; if (nv !== 1) $display("FAIL t1_valid_count: got %0d want 1", nv); else n_pass++;
    n_checks++; if (data_a !== 48'h000FFF123ABC) $display("FAIL t1_data: got %h want 000fff123abc", data_a); else n_pass++;
    n_checks++; if (err_a !== 4'b0000) $display("FAIL t1_err: got %b want 0000", err_a); else n_pass++;
  endtask

  task automatic test_frame_timing();
    int lat, falls, bc, nv; logic sf, sr;
    run_frame_a(16'h0A5A, 16'h05A5, 16'h0F0F, 16'h00F0, lat, falls, bc, nv, sf, sr);
    n_checks++; if (falls !== FB) $display("FAIL t2_sclk_falls: got %0d want %0d", falls, FB); else n_pass++;
    n_checks++; if (sf !== 1'b1) $display("FAIL t2_sclk_at_cs_fall: got %b want 1", sf); else n_pass++;
    n_checks++; if (sr !== 1'b1) $display("FAIL t2_sclk_at_cs_rise: got %b want 1", sr); else n_pass++;
    n_checks++; if (bc !== BUSY_A) $display("FAIL t2_busy_width: got %0d want %0d", bc, BUSY_A); else n_pass++;
    n_checks++; if (data_a !== 48'h0F0F0F5A5A5A) $display("FAIL t2_data: got %h want 0f0f0f5a5a5a", data_a); else n_pass++;
  endtask

  task automatic test_lead_err();
    int lat, falls, bc, nv; logic sf, sr;
    run_frame_a(16'h0ABC, 16'h0123, 16'h8555, 16'h0000, lat, falls, bc, nv, sf, sr);
    n_checks++; if (err_a !== 4'b0100) $display("FAIL t3_err: got %b want 0100", err_a); else n_pass++;
    n_checks++; if (data_a[35:24] !== 12'h555) $display("FAIL t3_ch2: got %h want 555", data_a[35:24]); else n_pass++;
    n_checks++; if (data_a !== 48'h000555123ABC) $display("FAIL t3_data: got %h want 000555123abc", data_a); else n_pass++;
  endtask

  // Extra starts at cycles 10, 40 and BUSY_A (last busy cycle) are dropped;
  // the start at BUSY_A+1 (first idle cycle) opens a second frame.
  task automatic test_start_ignored();
    int nv_first, nv_second;
    logic busy_last, busy_after, cs_after, cs_next;
    nv_first = 0; nv_second = 0;
    busy_last = 1'bx; busy_after = 1'bx; cs_after = 1'bx; cs_next = 1'bx;
    word_a[0] = 16'h0111; word_a[1] = 16'h0222; word_a[2] = 16'h0333; word_a[3] = 16'h0444;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a) begin
        if (c <= BUSY_A + 1) nv_first++; else nv_second++;
      end
      if (c == BUSY_A) busy_last = busy_a;
      if (c == BUSY_A + 1) begin busy_after = busy_a; cs_after = cs_a; end
      if (c == BUSY_A + 2) cs_next = cs_a;
      if (c == 10 || c == 40 || c == BUSY_A || c == BUSY_A + 1) start_a = 1'b1;
    end
    n_checks++; if (nv_first !== 1) $display("FAIL t4_valid_first: got %0d want 1", nv_first); else n_pass++;
    n_checks++; if (busy_last !== 1'b1) $display("FAIL t4_busy_last: got %b want 1", busy_last); else n_pass++;
    n_checks++; if ({busy_after, cs_after} !== 2'b01) $display("FAIL t4_idle_gap: got %b want 01", {busy_after, cs_after}); else n_pass++;
    n_checks++; if (cs_next !== 1'b0) $display("FAIL t4_restart_cs: got %b want 0", cs_next); else n_pass++;
    n_checks++; if (nv_second !== 1) $display("FAIL t4_valid_second: got %0d want 1", nv_second); else n_pass++;
    n_checks++; if (data_a !== 48'h444333222111) $display("FAIL t4_data: got %h want 444333222111", data_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nv, lat, falls, bc; logic sf, sr;
    nv = 0;
    word_a[0] = 16'h0AAA; word_a[1] = 16'h0BBB; word_a[2] = 16'h0CCC; word_a[3] = 16'h0DDD;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a) nv++;
    end
    reset = 1'b1;
    #1;
    n_checks++; if ({cs_a, sclk_a, busy_a} !== 3'b110) $display("FAIL t5_async_outputs: got %b want 110", {cs_a, sclk_a, busy_a}); else n_pass++;
    n_checks++; if ({err_a, data_a} !== 52'h0) $display("FAIL t5_async_data: got %h want 0", {err_a, data_a}); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (valid_a) nv++;
    end
    n_checks++; if (nv !== 0) $display("FAIL t5_no_valid: got %0d want 0", nv); else n_pass++;
    run_frame_a(16'h0FED, 16'h0CBA, 16'h0987, 16'h0654, lat, falls, bc, nv, sf, sr);
    n_checks++; if (lat !== LAT_A) $display("FAIL t5_latency: got %0d want %0d", lat, LAT_A); else n_pass++;
    n_checks++; if (data_a !== 48'h654987CBAFED) $display("FAIL t5_data: got %h want 654987cbafed", data_a); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, toggles, wait_cyc;
    logic pcs, psclk;
    logic [47:0] exp;
    // First frame on B: latency and one-cycle sclk half-period.
    word_b[0] = 16'h0321; word_b[1] = 16'h0654; word_b[2] = 16'h0987; word_b[3] = 16'h0CBA;
    lat = -1; toggles = 0;
    @(negedge clk);
    start_b = 1'b1;
    pcs = cs_b; psclk = sclk_b;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (!pcs && !cs_b && psclk != sclk_b) toggles++;
      if (valid_b && lat < 0) lat = c;
      pcs = cs_b; psclk = sclk_b;
    end
    n_checks++; if (lat !== LAT_B) $display("FAIL t6_latency: got %0d want %0d", lat, LAT_B); else n_pass++;
    n_checks++; if (toggles !== 2 * FB) $display("FAIL t6_sclk_toggles: got %0d want %0d", toggles, 2 * FB); else n_pass++;
    n_checks++; if (data_b !== 48'hCBA987654321) $display("FAIL t6_data0: got %h want cba987654321", data_b); else n_pass++;

    // 100 frames, each started on the first idle cycle after the previous one.
    for (int f = 0; f < 100; f++) begin
      wait_cyc = 0;
      while (busy_b && wait_cyc < 50) begin
        @(negedge clk);
        wait_cyc++;
      end
      for (int k = 0; k < 4; k++) word_b[k] = {4'h0, 12'($urandom)};
      exp = {word_b[3][11:0], word_b[2][11:0], word_b[1][11:0], word_b[0][11:0]};
      start_b = 1'b1;
      lat = -1;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
        @(negedge clk);
        start_b = 1'b0;
        if (valid_b) lat = c;
      end
      n_checks++; if (lat !== LAT_B) $display("FAIL t6_b2b_latency[%0d]: got %0d want %0d", f, lat, LAT_B); else n_pass++;
      n_checks++; if ({err_b, data_b} !== {4'h0, exp}) $display("FAIL t6_b2b_data[%0d]: got %h want %h", f, {err_b, data_b}, {4'h0, exp}); else n_pass++;
    end
    // Back-to-back gap: the last frame ends and the block goes idle next cycle.
    @(negedge clk);
    n_checks++; if (busy_b !== 1'b0) $display("FAIL t6_final_idle: got %b want 0", busy_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_timing();
    test_lead_err();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
